conv_skew_align: RTL and testbench

Parametrised skew/deskew stage for the conv array data path. It splits each group's word into LANES byte-lanes and delays lane k by a per-lane cycle count, forming the diagonal wavefront the systolic MAC array needs on input (SKEW) or realigning it on output (DESKEW). Unlike the fixed 9x18 input aligner, it adds the following:
- generic lane, group and width counts
- a direction mode
- a stall enable and a synchronous flush
- per-lane valid tags and a drain/busy indicator

---
 rtl/conv_pkg.sv | 27 ++
 rtl/skew_delay_line.sv | 40 ++++
 rtl/conv_skew_align.sv | 78 +++++++
 tb/tb_conv_skew_align.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and elaboration-time helpers for the conv array data path.
package conv_pkg;

  localparam int DIR_SKEW   = 0;
  localparam int DIR_DESKEW = 1;

  // Ceiling log2, used to size counters. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Number of enabled cycles that lane k is held back.
  // SKEW delays lane k by k and DESKEW by lanes-1-k.
  // The optional output register adds one uniform stage to every lane.
  function automatic int skew_delay(input int k, input int lanes, input int dir, input int out_reg);
    return ((dir == DIR_DESKEW) ? (lanes - 1 - k) : k) + out_reg;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register with synchronous flush. A depth of zero is a plain wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Control inputs have no effect when there is no storage.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rstn, en, clear};
      assign dout = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per enabled cycle.
      // Clear takes priority over en; with en low every stage holds.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/conv_skew_align.sv
// Skew/deskew stage for the conv array.
// Every byte-lane of every group is delayed by a per-lane cycle count.
// This builds the diagonal wavefront the systolic MAC array expects, or realigns it.
module conv_skew_align
  import conv_pkg::*;
#(
  parameter int LANES       = 9,
  parameter int GROUPS      = 18,
  parameter int DATA_WIDTH  = 8,
  parameter int DIRECTION   = DIR_SKEW,
  parameter int OUT_REG     = 0,
  parameter int GROUP_WIDTH = LANES * DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [GROUPS*GROUP_WIDTH-1:0] in_data,
  output logic [GROUPS*GROUP_WIDTH-1:0] out_data,
  output logic [LANES-1:0]              out_lane_valid,
  output logic                          busy
);

  // One delay line per lane carries that lane from all groups, plus one shared valid tag on top.
  localparam int LANE_WIDTH = GROUPS * DATA_WIDTH;
  localparam int MAXD       = LANES - 1 + OUT_REG;
  localparam int CNT_WIDTH  = clog2(MAXD + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAXD);

  logic [LANES-1:0][LANE_WIDTH:0] lane_in;
  logic [LANES-1:0][LANE_WIDTH:0] lane_out;
  logic [CNT_WIDTH-1:0]           cnt;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign lane_in[k][LANE_WIDTH] = in_valid;
      assign out_lane_valid[k]      = lane_out[k][LANE_WIDTH];

      for (genvar g = 0; g < GROUPS; g++) begin : g_group
        // Invalid beats are zeroed before entering the line, so downstream accumulators add nothing.
        assign lane_in[k][g*DATA_WIDTH +: DATA_WIDTH] =
          in_valid ? in_data[g*GROUP_WIDTH + k*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign out_data[g*GROUP_WIDTH + k*DATA_WIDTH +: DATA_WIDTH] =
          lane_out[k][g*DATA_WIDTH +: DATA_WIDTH];
      end

      skew_delay_line #(
        .DEPTH (skew_delay(k, LANES, DIRECTION, OUT_REG)),
        .WIDTH (LANE_WIDTH + 1)
      ) u_line (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .clear (clear),
        .din   (lane_in[k]),
        .dout  (lane_out[k])
      );
    end
  endgenerate

  // Drain counter. It is reloaded on every accepted beat and counts down while enabled.
  // It reaches zero once the slowest lane has emitted its last valid stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && in_valid) begin
      cnt <= CNT_MAX;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: tb/tb_conv_skew_align.sv
// Bench for conv_skew_align. It instantiates four configurations:
//   - the default 9x18 SKEW,
//   - a 3x2 SKEW feeding a 3x2 DESKEW,
//   - a 4x2 SKEW with the output register.
// A history-based reference model tracks them all.
module tb_conv_skew_align;

  localparam int BW = 1296;

  logic clk;
  logic rstn;
  logic en;
  logic clear;

  logic          v0;
  logic [BW-1:0] d0;
  logic [BW-1:0] o0;
  logic [8:0]    ov0;
  logic          b0;

  logic          vS;
  logic [47:0]   dS;
  logic [47:0]   oS;
  logic [2:0]    ovS;
  logic          bS;

  logic          vD;
  logic [47:0]   oD;
  logic [2:0]    ovD;
  logic          bD;

  logic          vR;
  logic [63:0]   dR;
  logic [63:0]   oR;
  logic [3:0]    ovR;
  logic          bR;

  int checks;
  int errors;

  // Reference model: per configuration, a history of accepted gated beats.
  // Index 0 holds the most recent beat.
  int cL   [4] = '{9, 3, 3, 4};
  int cG   [4] = '{18, 2, 2, 2};
  int cDir [4] = '{0, 0, 1, 0};
  int cOR  [4] = '{0, 0, 0, 1};
  logic          hv [4][10];
  logic [BW-1:0] hd [4][10];
  logic          mv [4];
  logic [BW-1:0] md [4];

  assign vD = |ovS;

  conv_skew_align u_dut0 (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear),
    .in_valid(v0), .in_data(d0), .out_data(o0), .out_lane_valid(ov0), .busy(b0)
  );

  conv_skew_align #(.LANES(3), .GROUPS(2), .DIRECTION(0)) u_dutS (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear),
    .in_valid(vS), .in_data(dS), .out_data(oS), .out_lane_valid(ovS), .busy(bS)
  );

  conv_skew_align #(.LANES(3), .GROUPS(2), .DIRECTION(1)) u_dutD (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear),
    .in_valid(vD), .in_data(oS), .out_data(oD), .out_lane_valid(ovD), .busy(bD)
  );

  conv_skew_align #(.LANES(4), .GROUPS(2), .OUT_REG(1)) u_dutR (
    .clk(clk), .rstn(rstn), .en(en), .clear(clear),
    .in_valid(vR), .in_data(dR), .out_data(oR), .out_lane_valid(ovR), .busy(bR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] rand1296();
    logic [BW-1:0] r;
    for (int i = 0; i < 40; i++) r[i*32 +: 32] = $urandom;
    r[1295:1280] = 16'($urandom);
    return r;
  endfunction

  function automatic int laneDelay(input int id, input int k);
    return ((cDir[id] != 0) ? (cL[id] - 1 - k) : k) + cOR[id];
  endfunction

  // Expected outputs come straight from the history.
  // Lane k shows the beat accepted laneDelay(k) enabled edges ago, or the live input at delay zero.
  // Busy means some valid beat has not yet reached the slowest lane.
  task automatic expOut(input int id, input logic v, input logic [BW-1:0] d,
                        output logic [BW-1:0] od, output logic [8:0] ov, output logic eb);
    int dl;
    int p;
    od = '0;
    ov = '0;
    eb = 1'b0;
    for (int k = 0; k < cL[id]; k++) begin
      dl = laneDelay(id, k);
      for (int g = 0; g < cG[id]; g++) begin
        p = (g * cL[id] + k) * 8;
        if (dl == 0) od[p +: 8] = v ? d[p +: 8] : 8'h00;
        else         od[p +: 8] = hd[id][dl-1][p +: 8];
      end
      ov[k] = (dl == 0) ? v : hv[id][dl-1];
    end
    for (int i = 0; i < cL[id] - 1 + cOR[id]; i++) eb = eb | hv[id][i];
  endtask

  task automatic computeInputs();
    logic [BW-1:0] td;
    logic [8:0]    tv;
    logic          tb;
    mv[0] = v0; md[0] = d0;
    mv[1] = vS; md[1] = BW'(dS);
    mv[3] = vR; md[3] = BW'(dR);
    expOut(1, vS, BW'(dS), td, tv, tb);
    mv[2] = |tv;
    md[2] = td;
  endtask

  task automatic modelReset();
    for (int id = 0; id < 4; id++)
      for (int i = 0; i < 10; i++) begin
        hv[id][i] = 1'b0;
        hd[id][i] = '0;
      end
  endtask

  task automatic modelEdge();
    computeInputs();
    if (!rstn) return;
    for (int id = 0; id < 4; id++) begin
      if (clear) begin
        for (int i = 0; i < 10; i++) begin
          hv[id][i] = 1'b0;
          hd[id][i] = '0;
        end
      end else if (en) begin
        for (int i = 9; i > 0; i--) begin
          hv[id][i] = hv[id][i-1];
          hd[id][i] = hd[id][i-1];
        end
        hv[id][0] = mv[id];
        hd[id][0] = mv[id] ? md[id] : '0;
      end
    end
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic a0, input logic aS,
                               input logic aR, input logic [47:0] s);
    en    = e;
    clear = c;
    v0    = a0;
    vS    = aS;
    vR    = aR;
    dS    = s;
    d0    = rand1296();
    dR    = {$urandom, $urandom};
  endtask

  task automatic checkOutput(input string tag);
    logic [BW-1:0] ed;
    logic [BW-1:0] ad;
    logic [8:0]    ev;
    logic [8:0]    av;
    logic          eb;
    logic          ab;
    int            gw;
    #1;
    computeInputs();
    for (int id = 0; id < 4; id++) begin
      expOut(id, mv[id], md[id], ed, ev, eb);
      case (id)
        0:       begin ad = o0;         av = ov0;       ab = b0; end
        1:       begin ad = BW'(oS);    av = 9'(ovS);   ab = bS; end
        2:       begin ad = BW'(oD);    av = 9'(ovD);   ab = bD; end
        default: begin ad = BW'(oR);    av = 9'(ovR);   ab = bR; end
      endcase
      gw = cL[id] * 8;
      for (int g = 0; g < cG[id]; g++) begin
        checks++;
        assert (ad[g*gw +: 72] === ed[g*gw +: 72]) else begin
          errors++;
          $error("[TB] FAIL %s dut%0d group%0d data: got %h expected %h",
                 tag, id, g, ad[g*gw +: 72], ed[g*gw +: 72]);
        end
      end
      checks++;
      assert (av === ev) else begin
        errors++;
        $error("[TB] FAIL %s dut%0d lane_valid: got %b expected %b", tag, id, av, ev);
      end
      checks++;
      assert (ab === eb) else begin
        errors++;
        $error("[TB] FAIL %s dut%0d busy: got %b expected %b", tag, id, ab, eb);
      end
    end
  endtask

  task automatic chkConst(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    modelReset();

    // Reset state: registered lanes are zero, while the zero-delay lane of the default config stays combinational.
    rstn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 48'h0);
    checkOutput("reset");
    chkConst("reset_outreg_lane0", oR, 64'h0);
    chkConst("reset_busy", {60'h0, b0, bS, bD, bR}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    checkOutput("post_reset");
    step();

    // Single SKEW beat through the 3-lane pair; the DESKEW copy realigns it.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 48'h131211_030201);
    checkOutput("skew_c0");
    chkConst("skew_c0_data", oS, 64'h000011_000001);
    chkConst("skew_c0_busy", bS, 64'h0);
    chkConst("outreg_c0_data", oR, 64'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'hdeadbeef_cafe);
    checkOutput("skew_c1");
    chkConst("skew_c1_data", oS, 64'h001200_000200);
    chkConst("skew_c1_busy", bS, 64'h1);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    checkOutput("skew_c2");
    chkConst("skew_c2_data", oS, 64'h130000_030000);
    chkConst("skew_c2_busy", bS, 64'h1);
    chkConst("deskew_c2_data", oD, 64'h131211_030201);
    chkConst("deskew_c2_valid", ovD, 64'h7);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    checkOutput("skew_c3");
    chkConst("skew_c3_busy", bS, 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
      checkOutput("skew_tail");
    end
    step();

    // Stall midway through a four-beat stream.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {6{8'(8'h10 + i)}});
      checkOutput("stall_pre");
      step();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, {$urandom, 16'($urandom)});
      checkOutput("stall_hold");
      step();
    end
    for (int i = 2; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {6{8'(8'h10 + i)}});
      checkOutput("stall_post");
      step();
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
      checkOutput("stall_drain");
      step();
    end

    // Flush one cycle after a beat enters, then a clear that collides with a new beat.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 48'h665544_332211);
    checkOutput("flush_beat");
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'h0);
    checkOutput("flush_clear");
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
    checkOutput("flush_after");
    chkConst("flush_after_valid", ov0, 64'h0);
    chkConst("flush_after_busy", b0, 64'h0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 48'h0a0b0c_0d0e0f);
    checkOutput("flush_collide");
    step();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
      checkOutput("flush_collide_after");
      if (i == 0) chkConst("flush_collide_busy", {60'h0, b0, bS, bD, bR}, 64'h0);
      step();
    end

    // Asynchronous reset in the middle of a random stream.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, {$urandom, 16'($urandom)});
      checkOutput("arst_stream");
      step();
    end
    rstn = 1'b0;
    modelReset();
    checkOutput("arst_low");
    chkConst("arst_outreg_data", oR, 64'h0);
    chkConst("arst_busy", {60'h0, b0, bS, bD, bR}, 64'h0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0);
      checkOutput("arst_release");
      step();
    end

    // Random traffic with stalls and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                    1'($urandom), 1'($urandom), 1'($urandom), {$urandom, 16'($urandom)});
      checkOutput("random");
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
